// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register: aligns and extends load data, qualifies the
// register-file write, flags misaligned loads and counts retired entries.
module wb_stage_pipe #(
    parameter int DATA_W            = 32,
    parameter int REG_ADDR_W        = 5,
    parameter int CNT_W             = 16,
    parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_stall,
    input  logic                  in_flush,
    input  logic                  in_mem_to_reg,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_write_back_destination,
    input  logic [DATA_W-1:0]     in_address,
    input  logic [DATA_W-1:0]     in_read_data,
    input  logic [1:0]            in_load_size,
    input  logic                  in_load_unsigned,
    output logic [DATA_W-1:0]     write_data_out,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] write_back_destination_out,
    output logic                  fwd_valid_out,
    output logic                  align_error_out,
    output logic [CNT_W-1:0]      retired_count_out
);

    localparam int OFF_W     = $clog2(DATA_W / 8);
    localparam int WORD_BITS = (DATA_W < 32) ? DATA_W : 32;

    logic                  valid_q;
    logic                  wen_q;
    logic                  misal_q;
    logic [DATA_W-1:0]     data_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [OFF_W-1:0]  offset;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] data_d;
    logic              misal_d;
    logic              wordMisal;
    logic              capture;
    logic              wen_d;

    // Keeps the low 'bits' bits of v and fills everything above with 'fill'.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input int bits,
                                                 input logic fill);
        logic [DATA_W-1:0] r;
        r = v;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= bits) r[i] = fill;
        end
        return r;
    endfunction

    assign offset  = in_address[OFF_W-1:0];
    assign capture = in_valid & ~in_stall & ~in_flush;

    generate
        if (OFF_W >= 2) begin : g_wordMisalWide
            assign wordMisal = |offset[1:0];
        end else begin : g_wordMisalNarrow
            assign wordMisal = offset[0];
        end
    endgenerate

    always_comb begin
        shifted = in_read_data >> {offset, 3'b000};
        data_d  = in_address;
        misal_d = 1'b0;
        if (!in_mem_to_reg) begin
            case (in_load_size)
                2'b00: data_d = extend(shifted, 8, ~in_load_unsigned & shifted[7]);
                2'b01: begin
                    data_d  = extend(shifted, 16, ~in_load_unsigned & shifted[15]);
                    misal_d = offset[0];
                end
                default: begin
                    data_d  = extend(in_read_data, WORD_BITS,
                                     ~in_load_unsigned & in_read_data[WORD_BITS-1]);
                    misal_d = wordMisal;
                end
            endcase
        end
    end

    assign wen_d = in_reg_write & ~misal_d &
                   ~(ZERO_REG_SUPPRESS && (in_write_back_destination == '0));

    // Stall, flush and idle cycles only clear valid; payload fields hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            misal_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= capture;
            if (capture) begin
                wen_q   <= wen_d;
                misal_q <= misal_d;
                data_q  <= data_d;
                dest_q  <= in_write_back_destination;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign write_data_out             = data_q;
    assign write_back_destination_out = dest_q;
    assign reg_write_out              = valid_q & wen_q;
    assign fwd_valid_out              = valid_q & wen_q;
    assign align_error_out            = valid_q & misal_q;
    assign retired_count_out          = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: a default instance plus a 4-bit counter
// instance share every input so the retire counter wrap can be observed.
module tb_wb_stage_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_stall;
    logic        in_flush;
    logic        in_mem_to_reg;
    logic        in_reg_write;
    logic [4:0]  in_write_back_destination;
    logic [31:0] in_address;
    logic [31:0] in_read_data;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;

    logic [31:0] writeData;
    logic        regWrite;
    logic [4:0]  wbDest;
    logic        fwdValid;
    logic        alignError;
    logic [15:0] retiredCount;

    logic [31:0] writeDataW;
    logic        regWriteW;
    logic [4:0]  wbDestW;
    logic        fwdValidW;
    logic        alignErrorW;
    logic [3:0]  retiredCountW;

    int totalCount = 0;
    int badCount   = 0;
    int expCnt     = 0;

    wb_stage_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_stall(in_stall),
        .in_flush(in_flush), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_write_back_destination(in_write_back_destination), .in_address(in_address),
        .in_read_data(in_read_data), .in_load_size(in_load_size),
        .in_load_unsigned(in_load_unsigned), .write_data_out(writeData),
        .reg_write_out(regWrite), .write_back_destination_out(wbDest),
        .fwd_valid_out(fwdValid), .align_error_out(alignError),
        .retired_count_out(retiredCount)
    );

    wb_stage_pipe #(.CNT_W(4)) dutWrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_stall(in_stall),
        .in_flush(in_flush), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_write_back_destination(in_write_back_destination), .in_address(in_address),
        .in_read_data(in_read_data), .in_load_size(in_load_size),
        .in_load_unsigned(in_load_unsigned), .write_data_out(writeDataW),
        .reg_write_out(regWriteW), .write_back_destination_out(wbDestW),
        .fwd_valid_out(fwdValidW), .align_error_out(alignErrorW),
        .retired_count_out(retiredCountW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, lets an edge pass, then samples 1 ns later.
    task automatic applyStimulus(input logic rst, input logic v, input logic st,
                                 input logic fl, input logic m2r, input logic rw,
                                 input logic [4:0] dst, input logic [31:0] addr,
                                 input logic [31:0] rd, input logic [1:0] sz,
                                 input logic uns);
        reset = rst; in_valid = v; in_stall = st; in_flush = fl;
        in_mem_to_reg = m2r; in_reg_write = rw; in_write_back_destination = dst;
        in_address = addr; in_read_data = rd; in_load_size = sz; in_load_unsigned = uns;
        @(posedge clk);
        #1;
        if (rst) expCnt = 0;
        else if (v && !st && !fl) expCnt++;
    endtask

    task automatic checkAll(input string tag, input logic [31:0] data, input logic rw,
                            input logic [4:0] dst, input logic err);
        checkOutput({tag, ".data"}, 64'(writeData), 64'(data));
        checkOutput({tag, ".rw"}, 64'(regWrite), 64'(rw));
        checkOutput({tag, ".dest"}, 64'(wbDest), 64'(dst));
        checkOutput({tag, ".fwd"}, 64'(fwdValid), 64'(rw));
        checkOutput({tag, ".err"}, 64'(alignError), 64'(err));
        checkOutput({tag, ".cnt"}, 64'(retiredCount), 64'(expCnt & 32'hFFFF));
        checkOutput({tag, ".cntW"}, 64'(retiredCountW), 64'(expCnt & 32'hF));
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        // Entry presented under reset is discarded.
        applyStimulus(1, 1, 0, 0, 1, 1, 5'd7, 32'hDEAD_BEEF, RD, 2'b10, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, 5'd7, 32'hDEAD_BEEF, RD, 2'b10, 0);
        checkAll("reset", 32'h0, 0, 5'd0, 0);

        applyStimulus(0, 1, 0, 0, 1, 1, 5'd5, 32'h0000_1234, RD, 2'b00, 0);
        checkAll("aluPass", 32'h0000_1234, 1, 5'd5, 0);

        applyStimulus(0, 1, 0, 0, 0, 1, 5'd6, 32'h0000_1003, RD, 2'b00, 0);
        checkAll("byteOff3S", 32'hFFFF_FF80, 1, 5'd6, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 5'd6, 32'h0000_1003, RD, 2'b00, 1);
        checkAll("byteOff3U", 32'h0000_0080, 1, 5'd6, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 5'd6, 32'h0000_1001, RD, 2'b00, 0);
        checkAll("byteOff1S", 32'h0000_007F, 1, 5'd6, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 5'd8, 32'h0000_1002, RD, 2'b01, 0);
        checkAll("halfOff2S", 32'hFFFF_80FF, 1, 5'd8, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 5'd8, 32'h0000_1000, RD, 2'b01, 1);
        checkAll("halfOff0U", 32'h0000_7F01, 1, 5'd8, 0);

        // Misaligned half: error for exactly one cycle, still retires.
        applyStimulus(0, 1, 0, 0, 0, 1, 5'd9, 32'h0000_1001, RD, 2'b01, 0);
        checkAll("halfMisal", 32'hFFFF_FF7F, 0, 5'd9, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd9, 32'h0000_1001, RD, 2'b01, 0);
        checkAll("idleAfterMisal", 32'hFFFF_FF7F, 0, 5'd9, 0);

        applyStimulus(0, 1, 0, 0, 0, 1, 5'd10, 32'h0000_1002, RD, 2'b10, 0);
        checkAll("wordMisal", 32'h80FF_7F01, 0, 5'd10, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 5'd11, 32'h0000_1000, RD, 2'b11, 0);
        checkAll("wordRsvd", 32'h80FF_7F01, 1, 5'd11, 0);

        // ALU results bypass the alignment check entirely.
        applyStimulus(0, 1, 0, 0, 1, 1, 5'd12, 32'h0000_1001, RD, 2'b01, 0);
        checkAll("aluNoAlign", 32'h0000_1001, 1, 5'd12, 0);

        applyStimulus(0, 1, 1, 1, 1, 1, 5'd13, 32'h0000_5555, RD, 2'b10, 0);
        checkAll("allThree", 32'h0000_1001, 0, 5'd12, 0);
        applyStimulus(0, 1, 1, 0, 1, 1, 5'd14, 32'h0000_6666, RD, 2'b10, 0);
        checkAll("stallBubble", 32'h0000_1001, 0, 5'd12, 0);
        applyStimulus(0, 1, 0, 0, 1, 1, 5'd15, 32'h0000_7777, RD, 2'b10, 0);
        checkAll("afterStall", 32'h0000_7777, 1, 5'd15, 0);

        applyStimulus(0, 1, 0, 0, 1, 1, 5'd0, 32'h0000_8888, RD, 2'b10, 0);
        checkAll("zeroDest", 32'h0000_8888, 0, 5'd0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 5'd3, 32'h0000_9999, RD, 2'b10, 0);
        checkAll("noRegWrite", 32'h0000_9999, 0, 5'd3, 0);

        // Reset while an entry is valid clears everything on the next edge.
        applyStimulus(0, 1, 0, 0, 1, 1, 5'd4, 32'h0000_AAAA, RD, 2'b10, 0);
        checkAll("preReset", 32'h0000_AAAA, 1, 5'd4, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, 5'd4, 32'h0000_BBBB, RD, 2'b10, 0);
        checkAll("midReset", 32'h0, 0, 5'd0, 0);
        applyStimulus(0, 1, 0, 0, 1, 1, 5'd2, 32'h0000_CCCC, RD, 2'b10, 0);
        checkAll("firstAfterReset", 32'h0000_CCCC, 1, 5'd2, 0);

        applyStimulus(1, 0, 0, 0, 1, 1, 5'd1, 32'h0, RD, 2'b10, 0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 1, 5'd1, 32'(i), RD, 2'b10, 0);
        end
        checkOutput("wrapCntW", 64'(retiredCountW), 64'd1);
        checkOutput("wrapCnt16", 64'(retiredCount), 64'd17);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
